// File: rtl/ram_responder.sv
// Wait-state RAM responder: latches one access request, waits WAIT_CYCLES cycles,
// performs the read or write, then pulses ack (and err for an illegal fetch-side write).
module ram_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  msel,
  input  logic                  mwrite,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] mdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic                  r_sel;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_mem_we;
  logic                  w_rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          w_next   = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request fields are captured only on acceptance, so input changes while busy are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_sel   <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= WAIT_LOAD;
      r_addr  <= msel ? c_addr : pc_addr;
      r_write <= mwrite;
      r_sel   <= msel;
      r_wdata <= wdata;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Fetch-side writes are suppressed; reset in the ACCESS cycle also blocks the write.
  assign w_mem_we = (r_state == S_ACCESS) && r_write && r_sel && !reset;
  assign w_rd_en  = (r_state == S_ACCESS) && !r_write;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdata <= '0;
    end else if (w_rd_en) begin
      r_mdata <= r_mem[r_addr];
    end
  end

  assign mdata = r_mdata;
  assign ack   = (r_state == S_RESP);
  assign err   = (r_state == S_RESP) && r_write && !r_sel;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, memory word and data-bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; depth = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, wait states inserted before each access.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  1  access request from the controller.
REQ-007 SHALL have port msel  input  1  address select: 0 = pc_addr (fetch), 1 = c_addr (data).
REQ-008 SHALL have port mwrite  input  1  1 = write, 0 = read.
REQ-009 SHALL have port pc_addr  input  ADDR_WIDTH  program-counter address.
REQ-010 SHALL have port c_addr  input  ADDR_WIDTH  effective address from datapath register C.
REQ-011 SHALL have port wdata  input  DATA_WIDTH  store data from datapath register B.
REQ-012 SHALL have port mdata  output  DATA_WIDTH  read data returned to the datapath.
REQ-013 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  one-cycle pulse, coincident with ack, for illegal access.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, ACCESS, RESP.
REQ-017 In IDLE with req=1, SHALL latch address (msel ? c_addr : pc_addr), mwrite, msel and wdata, then go to WAIT, or to ACCESS if WAIT_CYCLES=0.
REQ-018 In IDLE with req=0, SHALL remain in IDLE.
REQ-019 SHALL stay in WAIT for exactly WAIT_CYCLES cycles using a 4-bit down-counter, then go to ACCESS.
REQ-020 In ACCESS, for a latched write with msel=1, SHALL write the latched wdata to the latched address; mdata is unchanged.
REQ-021 In ACCESS, for a latched read, SHALL register mem[latched address] into mdata; either msel value is legal.
REQ-022 In ACCESS, for a latched write with msel=0, SHALL suppress the write, leave memory and mdata unchanged, and set err for the RESP cycle.
REQ-023 SHALL go from ACCESS to RESP, and from RESP to IDLE unconditionally.
REQ-024 ack SHALL be 1 only in RESP; err SHALL be 1 only in RESP, and only for an illegal access.
REQ-025 With req sampled in cycle N, ack SHALL occur in cycle N+WAIT_CYCLES+2; mdata SHALL be valid in that cycle.
REQ-026 mdata SHALL hold its value until the next completed read.
REQ-027 Input changes while busy=1 SHALL be ignored; req is sampled only in IDLE, so the earliest back-to-back acceptance is the cycle after ack.
REQ-028 A read of an address written by the previous access SHALL return the new data.
REQ-029 All addresses SHALL be in range; there SHALL be no wrap or out-of-range case.

Reset
REQ-030 While reset=1, SHALL force state=IDLE, wait counter=0, mdata=0, ack=0, err=0, busy=0.
REQ-031 reset SHALL override req in the same cycle.
REQ-032 Reset during WAIT or ACCESS SHALL abort the access; a pending write SHALL NOT be performed if reset is high in the ACCESS cycle.
REQ-033 Memory contents SHALL NOT be cleared by reset; all outputs SHALL be defined from the first cycle after reset.

Verification
REQ-034 Settings WAIT_CYCLES=1: write msel=1, c_addr=0x05, wdata=0x1234, req in cycle 0 -> ack in cycle 3, err=0; then read msel=1, c_addr=0x05 -> mdata=0x1234 with ack.
REQ-035 Fetch read msel=0, pc_addr=0x05, with c_addr=0x09 -> mdata=0x1234, which proves address select.
REQ-036 Illegal write msel=0, mwrite=1, pc_addr=0x05, wdata=0xFFFF -> ack=1 and err=1 in the same cycle; a later read of 0x05 returns 0x1234.
REQ-037 Settings WAIT_CYCLES=0, back-to-back reads of 0x00 and 0xFF with req held high -> acks in cycles 2 and 5, and busy=1 throughout both accesses except in the IDLE acceptance cycle.
REQ-038 Write 0xBEEF to 0x10, with reset pulsed in the WAIT cycle -> no ack, busy=0 and mdata=0 next cycle; a later read of 0x10 returns its prior value.
REQ-039 Change c_addr and wdata during WAIT -> the originally latched address and data are used.
